// File: rtl/regfile_port_arbiter.sv
// Shares a 2R1W register file between the core (A) and the debug port (B).
// Picks one winner per cycle and returns tagged read data one cycle later.
module regfile_port_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_WAIT      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_req,
  input  logic [ADDRESS_WIDTH-1:0] a_rs1,
  input  logic [ADDRESS_WIDTH-1:0] a_rs2,
  input  logic [ADDRESS_WIDTH-1:0] a_rd,
  input  logic                     a_we,
  input  logic [DATA_WIDTH-1:0]    a_wd,
  output logic                     a_gnt,
  output logic                     a_rvalid,
  output logic [DATA_WIDTH-1:0]    a_rd1,
  output logic [DATA_WIDTH-1:0]    a_rd2,
  input  logic                     b_req,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic                     b_we,
  input  logic [DATA_WIDTH-1:0]    b_wd,
  output logic                     b_gnt,
  output logic                     b_rvalid,
  output logic [DATA_WIDTH-1:0]    b_rdata,
  output logic [ADDRESS_WIDTH-1:0] rf_addr1,
  output logic [ADDRESS_WIDTH-1:0] rf_addr2,
  output logic [ADDRESS_WIDTH-1:0] rf_addr3,
  output logic                     rf_we3,
  output logic [DATA_WIDTH-1:0]    rf_wd3,
  input  logic [DATA_WIDTH-1:0]    rf_rd1,
  input  logic [DATA_WIDTH-1:0]    rf_rd2
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [1:0]            owner_q, owner_d;
  logic                  zero1_q, zero1_d;
  logic                  zero2_q, zero2_d;
  logic                  byp1_q, byp1_d;
  logic                  byp2_q, byp2_d;
  logic [DATA_WIDTH-1:0] fwd_wd_q, fwd_wd_d;

  logic a_win, b_win;
  logic we_sel;

  // Grants are suppressed during reset so nothing is written or launched.
  always_comb begin
    b_win = rst_n && b_req && (!a_req || (wait_cnt_q == WAIT_MAX));
    a_win = rst_n && a_req && !b_win;
    a_gnt = a_win;
    b_gnt = b_win;
  end

  always_comb begin
    rf_addr1 = '0;
    rf_addr2 = '0;
    rf_addr3 = '0;
    rf_wd3   = '0;
    we_sel   = 1'b0;
    if (a_win) begin
      rf_addr1 = a_rs1;
      rf_addr2 = a_rs2;
      rf_addr3 = a_rd;
      rf_wd3   = a_wd;
      we_sel   = a_we;
    end else if (b_win) begin
      rf_addr1 = b_addr;
      rf_addr3 = b_addr;
      rf_wd3   = b_wd;
      we_sel   = b_we;
    end
    rf_we3 = we_sel && (rf_addr3 != '0);
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!b_req || b_win) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    owner_d = OWN_NONE;
    if (a_win) begin
      owner_d = OWN_A;
    end else if (b_win) begin
      owner_d = OWN_B;
    end

    // rf_we3 already excludes x0, so it doubles as the nonzero-write qualifier.
    zero1_d  = (rf_addr1 == '0);
    zero2_d  = (rf_addr2 == '0);
    byp1_d   = rf_we3 && (rf_addr1 == rf_addr3);
    byp2_d   = rf_we3 && (rf_addr2 == rf_addr3);
    fwd_wd_d = rf_wd3;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
      owner_q    <= OWN_NONE;
      zero1_q    <= 1'b0;
      zero2_q    <= 1'b0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      fwd_wd_q   <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      owner_q    <= owner_d;
      zero1_q    <= zero1_d;
      zero2_q    <= zero2_d;
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      fwd_wd_q   <= fwd_wd_d;
    end
  end

  logic [DATA_WIDTH-1:0] port1_data, port2_data;

  // The regfile reads old contents on a same-edge write, hence the bypass.
  always_comb begin
    port1_data = zero1_q ? '0 : (byp1_q ? fwd_wd_q : rf_rd1);
    port2_data = zero2_q ? '0 : (byp2_q ? fwd_wd_q : rf_rd2);
    a_rvalid   = (owner_q == OWN_A);
    b_rvalid   = (owner_q == OWN_B);
    a_rd1      = a_rvalid ? port1_data : '0;
    a_rd2      = a_rvalid ? port2_data : '0;
    b_rdata    = b_rvalid ? port1_data : '0;
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 2R1W regfile and
// a scoreboard monitor that checks tagged read responses and their timing.
module tb_regfile_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_rs1, a_rs2, a_rd, b_addr;
  logic [DW-1:0] a_wd, b_wd;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rd1, a_rd2, b_rdata;
  logic [AW-1:0] rf_addr1, rf_addr2, rf_addr3;
  logic          rf_we3;
  logic [DW-1:0] rf_wd3, rf_rd1, rf_rd2;

  regfile_port_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_rs1(a_rs1), .a_rs2(a_rs2), .a_rd(a_rd), .a_we(a_we), .a_wd(a_wd),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rd1(a_rd1), .a_rd2(a_rd2),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_wd(b_wd),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_addr3(rf_addr3),
    .rf_we3(rf_we3), .rf_wd3(rf_wd3), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
  );

  always #5 clk = ~clk;

  // Behavioural register file: registered reads see pre-write contents.
  logic [DW-1:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
  always @(posedge clk) begin
    rf_rd1 <= mem[rf_addr1];
    rf_rd2 <= mem[rf_addr2];
    if (rf_we3) mem[rf_addr3] <= rf_wd3;
  end

  typedef struct {
    int          own;
    logic [31:0] d1;
    logic [31:0] d2;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Response monitor: pops one expectation per rvalid, flags late or stray data.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missing_rvalid_cycle", 32'(cyc), 32'(q[0].cyc));
        void'(q.pop_front());
      end
      if (a_rvalid === 1'b1 || b_rvalid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_rvalid", {30'd0, b_rvalid, a_rvalid}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_owner", {30'd0, b_rvalid, a_rvalid}, (e.own == 1) ? 32'd1 : 32'd2);
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
          if (e.own == 1) begin
            chk("a_rd1", a_rd1, e.d1);
            chk("a_rd2", a_rd2, e.d2);
            chk("b_rdata_idle", b_rdata, 32'd0);
          end else begin
            chk("b_rdata", b_rdata, e.d1);
            chk("a_rd1_idle", a_rd1, 32'd0);
          end
        end
      end else begin
        chk("idle_data", a_rd1 | a_rd2 | b_rdata, 32'd0);
      end
    end
  end

  task automatic set_a(input logic req, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic [31:0] wd);
    a_req = req; a_rs1 = rs1; a_rs2 = rs2; a_rd = rd; a_we = we; a_wd = wd;
  endtask

  task automatic set_b(input logic req, input logic [4:0] addr, input logic we,
                       input logic [31:0] wd);
    b_req = req; b_addr = addr; b_we = we; b_wd = wd;
  endtask

  task automatic expect_rsp(input int own, input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    e.own = own; e.d1 = d1; e.d2 = d2; e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_a(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 32'h0000_0BAD);
    set_b(1'b1, 5'd6, 1'b1, 32'h0000_0BAD);
    next_cycle();
    mon_en = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
      chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
      chk("rst_rf_we3", {31'd0, rf_we3}, 32'd0);
      chk("rst_rvalid", {30'd0, b_rvalid, a_rvalid}, 32'd0);
      next_cycle();
    end
    chk("rst_mem5_unchanged", mem[5], 32'h1000_0005);
    chk("rst_mem6_unchanged", mem[6], 32'h1000_0006);
    rst_n = 1'b1;
    set_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    set_b(1'b0, 5'd0, 1'b0, 32'd0);
    next_cycle();

    // A writes x5, then reads it back.
    set_a(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 32'hDEAD_BEEF);
    expect_rsp(1, 32'd0, 32'd0);
    @(negedge clk);
    chk("wr_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("wr_rf_we3", {31'd0, rf_we3}, 32'd1);
    chk("wr_rf_addr3", {27'd0, rf_addr3}, 32'd5);
    next_cycle();
    set_a(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 32'd0);
    expect_rsp(1, 32'hDEAD_BEEF, 32'd0);
    next_cycle();

    // Same-grant write and read of x7 must forward.
    set_a(1'b1, 5'd7, 5'd5, 5'd7, 1'b1, 32'h1234_5678);
    expect_rsp(1, 32'h1234_5678, 32'hDEAD_BEEF);
    next_cycle();

    // B writes x3 and reads it in the same grant.
    set_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    set_b(1'b1, 5'd3, 1'b1, 32'h0000_0055);
    expect_rsp(2, 32'h0000_0055, 32'd0);
    @(negedge clk);
    chk("b_gnt", {31'd0, b_gnt}, 32'd1);
    chk("b_rf_addr2", {27'd0, rf_addr2}, 32'd0);
    next_cycle();

    // B attempts to write x0.
    set_b(1'b1, 5'd0, 1'b1, 32'hFFFF_FFFF);
    expect_rsp(2, 32'd0, 32'd0);
    @(negedge clk);
    chk("x0_rf_we3", {31'd0, rf_we3}, 32'd0);
    next_cycle();

    set_b(1'b0, 5'd0, 1'b0, 32'd0);
    set_a(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 32'd0);
    expect_rsp(1, 32'd0, 32'h0000_0055);
    next_cycle();

    set_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("idle_gnts", {30'd0, b_gnt, a_gnt}, 32'd0);
    chk("idle_rf_addr1", {27'd0, rf_addr1}, 32'd0);
    next_cycle();

    // Starvation: B wins after four losses, then the counter restarts.
    set_a(1'b1, 5'd7, 5'd5, 5'd0, 1'b0, 32'd0);
    set_b(1'b1, 5'd7, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) expect_rsp(2, 32'h1234_5678, 32'd0);
      else                  expect_rsp(1, 32'h1234_5678, 32'hDEAD_BEEF);
      @(negedge clk);
      chk($sformatf("starve_gnts_%0d", i), {30'd0, b_gnt, a_gnt},
          (i == 4 || i == 9) ? 32'd2 : 32'd1);
      next_cycle();
    end
    set_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    set_b(1'b0, 5'd0, 1'b0, 32'd0);
    next_cycle();

    // Reset lands at the end of a read grant: the response is dropped.
    set_a(1'b1, 5'd5, 5'd7, 5'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("midrd_a_gnt", {31'd0, a_gnt}, 32'd1);
    #1;
    rst_n = 1'b0;
    next_cycle();
    set_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("midrd_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("midrd_a_rd1", a_rd1, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    set_a(1'b1, 5'd7, 5'd3, 5'd0, 1'b0, 32'd0);
    expect_rsp(1, 32'h1234_5678, 32'h0000_0055);
    next_cycle();
    set_a(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
